// File: rtl/fpu_muldiv_seq.sv
// Iterative IEEE-754 multiply/divide unit: shift-add multiply, restoring divide, RNE rounding.
// Optional FPU_STICKY_FLAGS_EN adds flags_clr / sticky_flags accumulation over completed results.
module fpu_muldiv_seq #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         invalid,
    output logic         div_by_zero
`ifdef FPU_STICKY_FLAGS_EN
    ,
    input  logic         flags_clr,
    output logic [3:0]   sticky_flags
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready depends only on state, and out_valid/result/flags hold until out_ready.
    localparam int SIG_W    = MAN_W + 1;
    localparam int EW2      = EXP_W + 2;
    localparam int ITER_MUL = SIG_W;
    localparam int ITER_DIV = SIG_W + 2;
    localparam int CNT_W    = $clog2(ITER_DIV + 1);

    localparam logic signed [EW2-1:0] BIAS_S   = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] EXP_ONE  = EW2'(1);
    localparam logic signed [EW2-1:0] EXP_ZERO = EW2'(0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CALC    = 3'd1,
        S_NORM    = 3'd2,
        S_SPECIAL = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic step_en, norm_en, spec_en, done_st, accept;

    logic                  op_q, sign_q;
    logic                  a_zero_q, a_inf_q, a_nan_q;
    logic                  b_zero_q, b_inf_q, b_nan_q;
    logic signed [EW2-1:0] exp_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [SIG_W:0]        hi_q;
    logic [SIG_W+1:0]      lo_q;
    logic [SIG_W-1:0]      dv_q;

    logic [W-1:0]          result_q;
    logic [3:0]            flags_q;
    logic                  out_valid_q;

    // Operand classification at the accept edge
    logic [EXP_W-1:0] a_exp, b_exp;
    logic             a_all1, b_all1, a_exp0, b_exp0, a_fnz, b_fnz, in_special;
    logic signed [EW2-1:0] ea_s, eb_s, exp_start;

    assign a_exp  = a[W-2 -: EXP_W];
    assign b_exp  = b[W-2 -: EXP_W];
    assign a_all1 = &a_exp;
    assign b_all1 = &b_exp;
    assign a_exp0 = ~|a_exp;
    assign b_exp0 = ~|b_exp;
    assign a_fnz  = |a[MAN_W-1:0];
    assign b_fnz  = |b[MAN_W-1:0];
    assign in_special = a_all1 | b_all1 | a_exp0 | b_exp0;
    assign ea_s = $signed({2'b00, a_exp});
    assign eb_s = $signed({2'b00, b_exp});
    assign exp_start = op ? (ea_s - eb_s + BIAS_S) : (ea_s + eb_s - BIAS_S);
    assign accept = in_valid & in_ready;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (accept) state_d = in_special ? S_SPECIAL : S_CALC;
            S_CALC:    if (cnt_q == '0) state_d = S_NORM;
            S_NORM:    state_d = S_DONE;
            S_SPECIAL: state_d = S_DONE;
            S_DONE:    if (out_valid_q && out_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = 1'b0;
        step_en  = 1'b0;
        norm_en  = 1'b0;
        spec_en  = 1'b0;
        done_st  = 1'b0;
        unique case (state_q)
            S_IDLE:    in_ready = 1'b1;
            S_CALC:    step_en  = 1'b1;
            S_NORM:    norm_en  = 1'b1;
            S_SPECIAL: spec_en  = 1'b1;
            S_DONE:    done_st  = 1'b1;
            default:   ;
        endcase
    end

    // One iteration of the shared mantissa datapath
    logic [SIG_W:0] mul_add;
    logic [SIG_W:0] div_diff, div_rem;
    logic           div_ge;

    always_comb begin
        mul_add  = lo_q[0] ? ({1'b0, hi_q[SIG_W-1:0]} + {1'b0, dv_q}) : {1'b0, hi_q[SIG_W-1:0]};
        div_ge   = hi_q >= {1'b0, dv_q};
        div_diff = hi_q - {1'b0, dv_q};
        div_rem  = div_ge ? div_diff : hi_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 1'b0;
            sign_q   <= 1'b0;
            a_zero_q <= 1'b0;
            a_inf_q  <= 1'b0;
            a_nan_q  <= 1'b0;
            b_zero_q <= 1'b0;
            b_inf_q  <= 1'b0;
            b_nan_q  <= 1'b0;
            exp_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dv_q     <= '0;
        end else if (accept) begin
            op_q     <= op;
            sign_q   <= a[W-1] ^ b[W-1];
            a_zero_q <= a_exp0;
            a_inf_q  <= a_all1 & ~a_fnz;
            a_nan_q  <= a_all1 & a_fnz;
            b_zero_q <= b_exp0;
            b_inf_q  <= b_all1 & ~b_fnz;
            b_nan_q  <= b_all1 & b_fnz;
            exp_q    <= exp_start;
            cnt_q    <= op ? CNT_W'(ITER_DIV - 1) : CNT_W'(ITER_MUL - 1);
            if (op) begin
                hi_q <= {2'b01, a[MAN_W-1:0]};
                lo_q <= '0;
                dv_q <= {1'b1, b[MAN_W-1:0]};
            end else begin
                hi_q <= '0;
                lo_q <= {3'b001, b[MAN_W-1:0]};
                dv_q <= {1'b1, a[MAN_W-1:0]};
            end
        end else if (step_en) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (op_q) begin
                hi_q <= div_rem << 1;
                lo_q <= {lo_q[SIG_W:0], div_ge};
            end else begin
                hi_q <= {1'b0, mul_add[SIG_W:1]};
                lo_q <= {2'b00, mul_add[0], lo_q[SIG_W-1:1]};
            end
        end
    end

    // Normalise (at most one bit), round to nearest even, then range-check
    logic [2*SIG_W-1:0]    prod;
    logic [SIG_W-1:0]      mant;
    logic [SIG_W:0]        mant_r;
    logic [MAN_W-1:0]      frac_r;
    logic                  guard, sticky, round_up, norm_ovf, norm_unf;
    logic signed [EW2-1:0] exp_n, exp_r;
    logic [W-1:0]          norm_result;

    always_comb begin
        prod   = {hi_q[SIG_W-1:0], lo_q[SIG_W-1:0]};
        mant   = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        exp_n  = exp_q;
        if (!op_q) begin
            if (prod[2*SIG_W-1]) begin
                mant   = prod[2*SIG_W-1 -: SIG_W];
                guard  = prod[SIG_W-1];
                sticky = |prod[SIG_W-2:0];
                exp_n  = exp_q + EXP_ONE;
            end else begin
                mant   = prod[2*SIG_W-2 -: SIG_W];
                guard  = prod[SIG_W-2];
                sticky = |prod[SIG_W-3:0];
            end
        end else begin
            // Quotient MSB has weight 2^0; a zero there means A's significand was below B's
            if (lo_q[SIG_W+1]) begin
                mant   = lo_q[SIG_W+1:2];
                guard  = lo_q[1];
                sticky = lo_q[0] | (|hi_q);
            end else begin
                mant   = lo_q[SIG_W:1];
                guard  = lo_q[0];
                sticky = |hi_q;
                exp_n  = exp_q - EXP_ONE;
            end
        end
        round_up = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + {{SIG_W{1'b0}}, round_up};
        if (mant_r[SIG_W]) begin
            frac_r = mant_r[MAN_W:1];
            exp_r  = exp_n + EXP_ONE;
        end else begin
            frac_r = mant_r[MAN_W-1:0];
            exp_r  = exp_n;
        end
        norm_ovf = exp_r >= EXP_MAX;
        norm_unf = !norm_ovf && (exp_r <= EXP_ZERO);
        if (norm_ovf)      norm_result = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (norm_unf) norm_result = {sign_q, {(W-1){1'b0}}};
        else               norm_result = {sign_q, exp_r[EXP_W-1:0], frac_r};
    end

    // Exceptional operands; NaN takes priority over every other case
    logic         spec_nan, spec_inf, spec_dbz;
    logic [W-1:0] spec_result;

    always_comb begin
        spec_nan = a_nan_q | b_nan_q |
                   (~op_q & ((a_zero_q & b_inf_q) | (a_inf_q & b_zero_q))) |
                   ( op_q & ((a_zero_q & b_zero_q) | (a_inf_q & b_inf_q)));
        spec_inf = op_q ? (a_inf_q | b_zero_q) : (a_inf_q | b_inf_q);
        spec_dbz = op_q & b_zero_q & ~a_zero_q & ~a_inf_q & ~spec_nan;
        if (spec_nan)      spec_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        else if (spec_inf) spec_result = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else               spec_result = {sign_q, {(W-1){1'b0}}};
    end

    // Output registers; flags_q = {div_by_zero, invalid, underflow, overflow}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (norm_en) begin
                result_q <= norm_result;
                flags_q  <= {2'b00, norm_unf, norm_ovf};
            end else if (spec_en) begin
                result_q <= spec_result;
                flags_q  <= {spec_dbz, spec_nan, 2'b00};
            end
            out_valid_q <= done_st & ~(out_valid_q & out_ready);
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign overflow    = flags_q[0];
    assign underflow   = flags_q[1];
    assign invalid     = flags_q[2];
    assign div_by_zero = flags_q[3];

`ifdef FPU_STICKY_FLAGS_EN
    // Bits raised by the completing result survive a simultaneous clear
    logic [3:0] sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= '0;
        else        sticky_q <= (flags_clr ? 4'b0000 : sticky_q) |
                                ((out_valid_q & out_ready) ? flags_q : 4'b0000);
    end

    assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_fpu_muldiv_seq.sv
// Bench for fpu_muldiv_seq in single precision: integer-arithmetic IEEE model, expected queue,
// directed vectors, backpressure and mid-operation reset.
module tb_fpu_muldiv_seq;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, op, out_valid, out_ready;
    logic [W-1:0] a, b, result;
    logic         overflow, underflow, invalid, div_by_zero;
    logic [3:0]   fl_dut;
`ifdef FPU_STICKY_FLAGS_EN
    logic         flags_clr;
    logic [3:0]   sticky_flags;
    logic [3:0]   exp_sticky = 4'b0000;
`endif

    always #5 clk = ~clk;

    assign fl_dut = {div_by_zero, invalid, underflow, overflow};

    fpu_muldiv_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .underflow(underflow), .invalid(invalid), .div_by_zero(div_by_zero)
`ifdef FPU_STICKY_FLAGS_EN
        , .flags_clr(flags_clr), .sticky_flags(sticky_flags)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [3:0]   exp_f_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // ---------------- reference model (single precision) ----------------
    function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] res, output logic [3:0] fl, output logic special);
        logic sx, sy, sg, zx, zy, ix, iy, nx, ny, g, s;
        int ex, ey, e, sh;
        longint unsigned mx, my, p, q, r, mant;
        sx = x[31]; sy = y[31]; sg = sx ^ sy;
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        zx = (ex == 0); zy = (ey == 0);
        ix = (ex == 255) && (x[22:0] == 0); iy = (ey == 255) && (y[22:0] == 0);
        nx = (ex == 255) && (x[22:0] != 0); ny = (ey == 255) && (y[22:0] != 0);
        special = zx || zy || (ex == 255) || (ey == 255);
        fl = 4'b0000;
        res = '0;
        if (special) begin
            if (nx || ny || (!o && ((zx && iy) || (ix && zy))) || (o && ((zx && zy) || (ix && iy)))) begin
                res = 32'h7FC00000; fl = 4'b0100;
            end else if (!o) begin
                res = (ix || iy) ? {sg, 8'hFF, 23'd0} : {sg, 31'd0};
            end else if (ix) begin
                res = {sg, 8'hFF, 23'd0};
            end else if (zy) begin
                res = {sg, 8'hFF, 23'd0}; fl = 4'b1000;
            end else begin
                res = {sg, 31'd0};
            end
            return;
        end
        mx = 64'h800000 | 64'(x[22:0]);
        my = 64'h800000 | 64'(y[22:0]);
        if (!o) begin
            p = mx * my;
            e = ex + ey - 127;
            if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
            else sh = 23;
            mant = p >> sh;
            g = ((p >> (sh - 1)) & 64'd1) != 0;
            s = (p & ((64'd1 << (sh - 1)) - 1)) != 0;
        end else begin
            q = (mx << 26) / my;
            r = (mx << 26) % my;
            e = ex - ey + 127;
            if (q >= (64'd1 << 26)) begin
                mant = q >> 3; g = ((q >> 2) & 64'd1) != 0; s = ((q & 64'd3) != 0) || (r != 0);
            end else begin
                e = e - 1;
                mant = q >> 2; g = ((q >> 1) & 64'd1) != 0; s = ((q & 64'd1) != 0) || (r != 0);
            end
        end
        if (g && (s || (mant & 64'd1) != 0)) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin mant = mant >> 1; e = e + 1; end
        if (e >= 255) begin
            res = {sg, 8'hFF, 23'd0}; fl = 4'b0001;
        end else if (e <= 0) begin
            res = {sg, 31'd0}; fl = 4'b0010;
        end else begin
            res = {sg, 8'(e), 23'(mant)};
        end
    endfunction

    // ---------------- scoreboard: compare every cycle out_valid is high ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
`ifdef FPU_STICKY_FLAGS_EN
            exp_sticky = 4'b0000;
`endif
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("result", result, exp_q[0]);
                check("flags", fl_dut, exp_f_q[0]);
                if (out_ready) begin
`ifdef FPU_STICKY_FLAGS_EN
                    exp_sticky = exp_sticky | exp_f_q[0];
`endif
                    void'(exp_q.pop_front());
                    void'(exp_f_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input logic o, input logic [31:0] av, input logic [31:0] bv, input int hold);
        logic [31:0] er;
        logic [3:0]  ef;
        logic        sp;
        int          n, lat, lat_exp;
        model(o, av, bv, er, ef, sp);
        exp_q.push_back(er);
        exp_f_q.push_back(ef);
        lat_exp = sp ? 2 : (o ? 28 : 26);
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("in_ready_before_accept", in_ready, 1);
        out_ready = (hold == 0);
        op = o; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check("latency", lat, lat_exp);
        if (hold > 0) begin
            repeat (hold) begin
                check("bp_in_ready_low", in_ready, 0);
                in_valid = 1'b1; op = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
                @(posedge clk); #1;
                check("bp_out_valid_held", out_valid, 1);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            check("release_out_valid_low", out_valid, 0);
            check("release_in_ready_high", in_ready, 1);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pin_model(input string name, input logic o, input logic [31:0] x, input logic [31:0] y,
                             input logic [35:0] req);
        logic [31:0] r;
        logic [3:0]  f;
        logic        sp;
        model(o, x, y, r, f, sp);
        check(name, {f, r}, req);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b1;
`ifdef FPU_STICKY_FLAGS_EN
        flags_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_flags", fl_dut, 0);
`ifdef FPU_STICKY_FLAGS_EN
        check("reset_sticky", sticky_flags, 0);
`endif
        rst_n = 1'b1;

        // Hand-computed expectations pin the model: {flags, result}
        pin_model("model_mul_3x2",    1'b0, 32'h40400000, 32'h40000000, {4'b0000, 32'h40C00000});
        pin_model("model_div_1by3",   1'b1, 32'h3F800000, 32'h40400000, {4'b0000, 32'h3EAAAAAB});
        pin_model("model_div_by_0",   1'b1, 32'h3F800000, 32'h00000000, {4'b1000, 32'h7F800000});
        pin_model("model_0xinf",      1'b0, 32'h00000000, 32'h7F800000, {4'b0100, 32'h7FC00000});
        pin_model("model_overflow",   1'b0, 32'h7F000000, 32'h40000000, {4'b0001, 32'h7F800000});
        pin_model("model_underflow",  1'b0, 32'h00800000, 32'h3F000000, {4'b0010, 32'h00000000});
        pin_model("model_neg_mul",    1'b0, 32'hC0000000, 32'h40400000, {4'b0000, 32'hC0C00000});
        pin_model("model_1p5_sq",     1'b0, 32'h3FC00000, 32'h3FC00000, {4'b0000, 32'h40100000});

        @(posedge clk); #1;
        do_op(1'b0, 32'h40400000, 32'h40000000, 0);
        do_op(1'b1, 32'h3F800000, 32'h40400000, 5);  // backpressure, then back-to-back below
        do_op(1'b1, 32'h3F800000, 32'h00000000, 0);
        do_op(1'b0, 32'h00000000, 32'h7F800000, 0);
        do_op(1'b0, 32'h7F000000, 32'h40000000, 0);
        do_op(1'b0, 32'h00800000, 32'h3F000000, 0);
        do_op(1'b0, 32'hC0000000, 32'h40400000, 0);
        do_op(1'b1, 32'h40C00000, 32'h40400000, 0);
        do_op(1'b1, 32'hC1200000, 32'h40000000, 0);
        do_op(1'b1, 32'h7F800000, 32'hFF800000, 0);
        do_op(1'b1, 32'h00000000, 32'h80000000, 0);
        do_op(1'b0, 32'h7FA00000, 32'h3F800000, 0);
        do_op(1'b1, 32'h40000000, 32'h7F800000, 0);
        do_op(1'b0, 32'h00000001, 32'h40000000, 0);
        do_op(1'b0, 32'hFF800000, 32'h40000000, 0);
        do_op(1'b1, 32'h00800000, 32'h4B000000, 0);
        do_op(1'b1, 32'h7F000000, 32'h00800000, 0);
        do_op(1'b0, 32'h3FFFFFFF, 32'h3FFFFFFF, 0);
        do_op(1'b0, 32'h3F800001, 32'h3F7FFFFF, 0);
        do_op(1'b1, 32'h3F7FFFFF, 32'h3F800001, 0);
        do_op(1'b1, 32'hBFA00000, 32'h3FE00000, 0);
        do_op(1'b0, 32'h3FC00000, 32'h3FC00000, 0);

`ifdef FPU_STICKY_FLAGS_EN
        check("sticky_accumulated", sticky_flags, exp_sticky);
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        exp_sticky = 4'b0000;
        check("sticky_cleared", sticky_flags, 0);
`endif

        // Abort a DIV mid-CALC with an asynchronous reset
        op = 1'b1; a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort_in_calc", in_ready, 0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_output", out_valid, 0);
        do_op(1'b0, 32'h40400000, 32'h40000000, 0);

        check("queue_drained", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
